// File: rtl/tp_step_gen.sv
// Stepper STEP/DIR/ENABLE pulse generator with clamped period, DIR setup hold and runt-free stop.
// Optional signed step position counter is enabled by defining TP_POS_CNT_EN.
module tp_step_gen #(
    parameter int WIDTH_TP  = 16,
    parameter int PULSE_W   = 4,
    parameter int DIR_SETUP = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                drv_en,
    input  logic                dir,
    input  logic [WIDTH_TP-1:0] period,
    input  logic                period_valid,
    output logic                step,
    output logic                dir_out,
    output logic                en_out,
    output logic                busy,
    output logic [31:0]         pos
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DIR_WAIT = 2'd1;
    localparam logic [1:0] S_STEP_HI  = 2'd2;
    localparam logic [1:0] S_STEP_LO  = 2'd3;

    localparam logic [WIDTH_TP-1:0] ZERO_V  = {WIDTH_TP{1'b0}};
    localparam logic [WIDTH_TP-1:0] ONE_V   = {{(WIDTH_TP-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_TP-1:0] PW_V    = WIDTH_TP'(PULSE_W);
    localparam logic [WIDTH_TP-1:0] PW_M1   = WIDTH_TP'(PULSE_W - 1);
    localparam logic [WIDTH_TP-1:0] DS_M1   = WIDTH_TP'(DIR_SETUP - 1);
    localparam logic [WIDTH_TP-1:0] MIN_EFF = WIDTH_TP'(2 * PULSE_W);

    logic [1:0]          state_q, state_d;
    logic [WIDTH_TP-1:0] cnt_q, cnt_d;
    logic [WIDTH_TP-1:0] eff_q, eff_d;
    logic [WIDTH_TP-1:0] period_q, period_d;
    logic                stop_seen_q, stop_seen_d;
    logic                dir_out_q, dir_out_d;
    logic                step_q, step_d;
    logic                busy_q, busy_d;
    logic                en_q;

    logic [WIDTH_TP-1:0] eff_s;
    logic [WIDTH_TP-1:0] lo_last_s;
    logic                stop_s;
    logic                stop_any_s;

    // Clamped interval, last low-phase count and stop request decode
    always_comb begin
        eff_s      = (period_q > MIN_EFF) ? period_q : MIN_EFF;
        lo_last_s  = eff_q - PW_V - ONE_V;
        stop_s     = (!drv_en) || (period_q == ZERO_V);
        stop_any_s = stop_s || stop_seen_q;
    end

    // Next-state logic for the pulse sequencer; a stop never cuts STEP high or low below PULSE_W
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        eff_d       = eff_q;
        stop_seen_d = stop_seen_q;
        dir_out_d   = dir_out_q;
        case (state_q)
            S_IDLE: begin
                cnt_d       = ZERO_V;
                stop_seen_d = 1'b0;
                if (drv_en && (period_q != ZERO_V)) begin
                    if (dir == dir_out_q) begin
                        state_d = S_STEP_HI;
                        eff_d   = eff_s;
                    end else begin
                        state_d   = S_DIR_WAIT;
                        dir_out_d = dir;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIR_WAIT: begin
                if (stop_s) begin
                    state_d = S_IDLE;
                    cnt_d   = ZERO_V;
                end else if (cnt_q == DS_M1) begin
                    state_d = S_STEP_HI;
                    cnt_d   = ZERO_V;
                    eff_d   = eff_s;
                end else begin
                    cnt_d = cnt_q + ONE_V;
                end
            end
            S_STEP_HI: begin
                stop_seen_d = stop_any_s;
                if (cnt_q == PW_M1) begin
                    state_d = S_STEP_LO;
                    cnt_d   = ZERO_V;
                end else begin
                    cnt_d = cnt_q + ONE_V;
                end
            end
            S_STEP_LO: begin
                stop_seen_d = stop_any_s;
                if (stop_any_s && (cnt_q >= PW_M1)) begin
                    state_d     = S_IDLE;
                    cnt_d       = ZERO_V;
                    stop_seen_d = 1'b0;
                end else if (cnt_q == lo_last_s) begin
                    cnt_d = ZERO_V;
                    if (dir != dir_out_q) begin
                        state_d   = S_DIR_WAIT;
                        dir_out_d = dir;
                    end else begin
                        state_d = S_STEP_HI;
                        eff_d   = eff_s;
                    end
                end else begin
                    cnt_d = cnt_q + ONE_V;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cnt_d       = ZERO_V;
                stop_seen_d = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so pins change on the same edge as the state
    always_comb begin
        step_d   = (state_d == S_STEP_HI);
        busy_d   = (state_d != S_IDLE);
        if (period_valid) begin
            period_d = period;
        end else begin
            period_d = period_q;
        end
    end

    // State, counters and registered pins
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= ZERO_V;
            eff_q       <= ZERO_V;
            period_q    <= ZERO_V;
            stop_seen_q <= 1'b0;
            dir_out_q   <= 1'b0;
            step_q      <= 1'b0;
            busy_q      <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            eff_q       <= eff_d;
            period_q    <= period_d;
            stop_seen_q <= stop_seen_d;
            dir_out_q   <= dir_out_d;
            step_q      <= step_d;
            busy_q      <= busy_d;
            en_q        <= drv_en;
        end
    end

`ifdef TP_POS_CNT_EN
    logic [31:0] pos_q;

    // Signed position: one count per STEP rising edge, wraps silently
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= 32'd0;
        end else if (step_d && !step_q) begin
            pos_q <= dir_out_q ? (pos_q + 32'd1) : (pos_q - 32'd1);
        end else begin
            pos_q <= pos_q;
        end
    end

    assign pos = pos_q;
`else
    assign pos = 32'd0;
`endif

    assign step    = step_q;
    assign dir_out = dir_out_q;
    assign en_out  = en_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_tp_step_gen.sv
// Bench for tp_step_gen: timestamp-based behavioural model checked every cycle, plus directed
// rising-edge spacing and pin expectations computed by hand for PULSE_W=4, DIR_SETUP=8.
module tb_tp_step_gen;

    localparam int W  = 16;
    localparam int PW = 4;
    localparam int DS = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         drv_en;
    logic         dir;
    logic [W-1:0] period;
    logic         period_valid;
    logic         step;
    logic         dir_out;
    logic         en_out;
    logic         busy;
    logic [31:0]  pos;

    tp_step_gen #(.WIDTH_TP(W), .PULSE_W(PW), .DIR_SETUP(DS)) dut (
        .clk(clk), .rst(rst), .drv_en(drv_en), .dir(dir), .period(period),
        .period_valid(period_valid), .step(step), .dir_out(dir_out), .en_out(en_out),
        .busy(busy), .pos(pos)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int rises[$];

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, n, act, exp);
        end
    endfunction

    // Model: a pulse is a rise time plus a latched interval; everything else is age arithmetic.
    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;
    int          m_mode = M_IDLE;
    int          m_rise = 0;
    int          m_wait = 0;
    int          m_eff  = 0;
    int          m_per  = 0;
    int          m_age;
    bit          m_flag = 1'b0;
    bit          m_dir  = 1'b0;
    bit          m_stop;
    bit          m_step = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_en   = 1'b0;
    logic [31:0] m_pos  = 32'd0;

    function void m_fire();
        m_mode = M_RUN;
        m_rise = n;
        m_eff  = (m_per > 2 * PW) ? m_per : 2 * PW;
        m_flag = 1'b0;
`ifdef TP_POS_CNT_EN
        m_pos = m_dir ? m_pos + 32'd1 : m_pos - 32'd1;
`endif
    endfunction

    always @(posedge clk) begin
        n = n + 1;
        if (rst) begin
            m_mode = M_IDLE;
            m_dir  = 1'b0;
            m_per  = 0;
            m_pos  = 32'd0;
            m_flag = 1'b0;
            m_en   = 1'b0;
        end else begin
            m_stop = !drv_en || (m_per == 0);
            m_age  = n - m_rise;
            case (m_mode)
                M_IDLE: if (!m_stop) begin
                    if (dir == m_dir) m_fire();
                    else begin m_dir = dir; m_wait = n; m_mode = M_WAIT; end
                end
                M_WAIT: if (m_stop) m_mode = M_IDLE;
                        else if (n - m_wait == DS) m_fire();
                default: begin
                    m_flag = m_flag | m_stop;
                    if (m_age > PW) begin
                        if (m_flag && m_age >= 2 * PW) m_mode = M_IDLE;
                        else if (m_age == m_eff) begin
                            if (dir != m_dir) begin m_dir = dir; m_wait = n; m_mode = M_WAIT; end
                            else m_fire();
                        end
                    end
                end
            endcase
            if (period_valid) m_per = int'(period);
            m_en = drv_en;
        end
        m_step = (m_mode == M_RUN) && ((n - m_rise) < PW);
        m_busy = (m_mode != M_IDLE);
    end

    bit prev_step = 1'b0;
    always @(posedge clk) begin
        #1;
        chk("step", {31'd0, step}, {31'd0, m_step});
        chk("dir_out", {31'd0, dir_out}, {31'd0, m_dir});
        chk("en_out", {31'd0, en_out}, {31'd0, m_en});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("pos", pos, m_pos);
        if (step === 1'b1 && !prev_step) rises.push_back(n);
        prev_step = (step === 1'b1);
    end

    function int sp(input int i);
        if (i >= 0 && i + 1 < rises.size()) return rises[i+1] - rises[i];
        return -1;
    endfunction

    task automatic wait_fresh_rise();
        for (int i = 0; i < 80 && step !== 1'b0; i++) @(negedge clk);
        for (int i = 0; i < 80 && step !== 1'b1; i++) @(negedge clk);
        chk("wait_rise", {31'd0, step}, 32'd1);
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    int e0;
    int idx;
    int cnt;

    initial begin
        rst = 1'b1; drv_en = 1'b0; dir = 1'b0; period = '0; period_valid = 1'b0;
        cycles(3);
        chk("rst_step", {31'd0, step}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        cycles(2);

        // 1: period 20, first rise on the edge that samples drv_en
        period = 16'd20; period_valid = 1'b1;
        cycles(1);
        period_valid = 1'b0; drv_en = 1'b1; dir = 1'b0;
        rises.delete(); e0 = n;
        cycles(1);
        chk("t1_en_out", {31'd0, en_out}, 32'd1);
        chk("t1_step_up", {31'd0, step}, 32'd1);
        cycles(69);
        chk("t1_first_rise", rises.size() > 0 ? rises[0] : -1, e0 + 1);
        chk("t1_space_a", sp(0), 32'd20);
        chk("t1_space_b", sp(1), 32'd20);

        // 2: period 3 clamps to 8
        period = 16'd3; period_valid = 1'b1;
        cycles(1);
        period_valid = 1'b0;
        cycles(60);
        chk("t2_clamp_a", sp(rises.size() - 2), 32'd8);
        chk("t2_clamp_b", sp(rises.size() - 3), 32'd8);

        // 3: reversal mid-interval at period 20
        period = 16'd20; period_valid = 1'b1;
        cycles(1);
        period_valid = 1'b0;
        cycles(30);
        wait_fresh_rise();
        cycles(6);
        idx = rises.size();
        dir = 1'b1;
        cycles(60);
        chk("t3_reversal", sp(idx - 1), 32'd28);
        chk("t3_after", sp(idx), 32'd20);
        chk("t3_dir_out", {31'd0, dir_out}, 32'd1);

        // 4: stop on second STEP_HI cycle
        wait_fresh_rise();
        drv_en = 1'b0;
        cnt = rises.size();
        cycles(3);
        chk("t4_still_high", {31'd0, step}, 32'd1);
        cycles(1);
        chk("t4_low", {31'd0, step}, 32'd0);
        cycles(3);
        chk("t4_busy_lo", {31'd0, busy}, 32'd1);
        cycles(1);
        chk("t4_idle", {31'd0, busy}, 32'd0);
        cycles(20);
        chk("t4_no_more", rises.size(), cnt);

        // 5: period 40 loaded during STEP_LO
        drv_en = 1'b1;
        wait_fresh_rise();
        cycles(8);
        period = 16'd40; period_valid = 1'b1;
        idx = rises.size();
        cycles(1);
        period_valid = 1'b0;
        cycles(100);
        chk("t5_current", sp(idx - 1), 32'd20);
        chk("t5_next_a", sp(idx), 32'd40);
        chk("t5_next_b", sp(idx + 1), 32'd40);

        // 6: reset in STEP_HI
        wait_fresh_rise();
        rst = 1'b1;
        cycles(1);
        chk("t6_step", {31'd0, step}, 32'd0);
        chk("t6_dir_out", {31'd0, dir_out}, 32'd0);
        chk("t6_pos", pos, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0; drv_en = 1'b0; dir = 1'b0;
        cycles(2);

        // 7: period load and stop in the same cycle
        period = 16'd20; period_valid = 1'b1;
        cycles(1);
        period_valid = 1'b0; drv_en = 1'b1;
        wait_fresh_rise();
        cycles(10);
        drv_en = 1'b0; period = 16'd12; period_valid = 1'b1;
        cycles(1);
        period_valid = 1'b0;
        cycles(2);
        chk("t7_stopped", {31'd0, busy}, 32'd0);
        drv_en = 1'b1;
        idx = rises.size();
        cycles(30);
        chk("t7_loaded", sp(idx), 32'd12);

        // 8: stop during DIR_WAIT gives no pulse
        drv_en = 1'b0;
        cycles(15);
        dir = 1'b1; drv_en = 1'b1;
        cnt = rises.size();
        cycles(3);
        chk("t8_waiting", {31'd0, busy}, 32'd1);
        drv_en = 1'b0;
        cycles(2);
        chk("t8_idle", {31'd0, busy}, 32'd0);
        cycles(20);
        chk("t8_no_pulse", rises.size(), cnt);
        chk("t8_dir_out", {31'd0, dir_out}, 32'd1);

        // 9: period 0 stops a running motor
        drv_en = 1'b1;
        cycles(30);
        period = 16'd0; period_valid = 1'b1;
        cycles(1);
        period_valid = 1'b0;
        cycles(30);
        chk("t9_zero_stop", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
